// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S_FILL,
    S_HUNT,
    S_HIT
  } seq_state_t;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;

  // Bits needed to hold a fill count of 0..pat_w inclusive.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones, never wraps.
// Latency: count updates on the incrementing edge.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector with overlap/flush modes and saturating match count.
// Latency: match pulses one cycle after the accepting edge; en=0 holds the window.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         din,
  input  logic                         overlap,
  input  logic                         clear,
  output logic                         match,
  output logic [CNT_W-1:0]             match_cnt,
  output logic [fill_width(PAT_W)-1:0] fill
);

  localparam int             FW   = fill_width(PAT_W);
  localparam logic [FW-1:0]  FULL = FW'(PAT_W);

  generate
    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
      $error("seq_detector: PAT_W must be in 2..16");
    end
  endgenerate

  seq_state_t       state_q, state_d;
  logic [PAT_W-1:0] window_q, window_d;
  logic [FW-1:0]    fill_q, fill_d;

  logic             accept;
  logic [PAT_W-1:0] win_shift;
  logic [FW-1:0]    fill_inc;
  logic             hit;

  assign accept    = en & ~clear;
  assign win_shift = {window_q[PAT_W-2:0], din};
  assign fill_inc  = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
  assign hit       = accept && (fill_inc == FULL) && (win_shift == PATTERN);

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    fill_d   = fill_q;
    if (clear) begin
      state_d  = S_FILL;
      window_d = '0;
      fill_d   = '0;
    end else if (accept) begin
      window_d = win_shift;
      fill_d   = fill_inc;
      if (hit) begin
        state_d = S_HIT;
        // Non-overlapping: flush wins over the shift on the hit edge.
        if (!overlap) begin
          window_d = '0;
          fill_d   = '0;
        end
      end else begin
        state_d = (fill_inc == FULL) ? S_HUNT : S_FILL;
      end
    end else if (state_q == S_HIT) begin
      state_d = overlap ? S_HUNT : S_FILL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FILL;
      window_q <= '0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      fill_q   <= fill_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (hit),
    .q     (match_cnt)
  );

  assign match = (state_q == S_HIT);
  assign fill  = fill_q;

endmodule
